// File: rtl/aes_req_sched.sv
// -----------------------------------------------------------------------------
// aes_req_sched
// Round-robin scheduler that time-shares one AES128 core among NUM_REQ
// requesters. It owns every control input of the core (key, start pulse,
// text/mode hold and core reset). A timeout watchdog recovers a hung core.
//
// The core latches its key only on the first start after its reset. For that
// reason every key change passes through a short core reset sequence (KRST)
// before the next job is started.
//
// Ports:
//   i_Clk, i_Rst            clock, asynchronous active-low reset
//   i_KeyLoad, i_Key        key load pulse and the new key (becomes pending)
//   i_ReqValid/Dec/Text     per-requester job request, mode and 128-bit block
//   o_ReqReady              one-hot accept pulse, one cycle long
//   o_RspValid/Data/Err     one-hot result pulse, result data, timeout flag
//   o_Busy, o_KeyValid      scheduler not idle / a key is installed
//   o_CoreRst_n ... o_CoreKey   drive the core's reset, start, mode, text, key
//   i_CoreData, i_CoreDone  core result and done strobe
// -----------------------------------------------------------------------------
module aes_req_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_KeyLoad,
    input  logic [127:0]             i_Key,
    input  logic [NUM_REQ-1:0]       i_ReqValid,
    input  logic [NUM_REQ-1:0]       i_ReqDec,
    input  logic [128*NUM_REQ-1:0]   i_ReqText,
    output logic [NUM_REQ-1:0]       o_ReqReady,
    output logic [NUM_REQ-1:0]       o_RspValid,
    output logic [127:0]             o_RspData,
    output logic                     o_RspErr,
    output logic                     o_Busy,
    output logic                     o_KeyValid,
    output logic                     o_CoreRst_n,
    output logic                     o_CoreStart,
    output logic                     o_CoreDec,
    output logic [127:0]             o_CoreText,
    output logic [127:0]             o_CoreKey,
    input  logic [127:0]             i_CoreData,
    input  logic                     i_CoreDone
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // The timeout fires in the WAIT cycle where the incremented count would
    // reach TIMEOUT, i.e. TIMEOUT cycles after the start pulse.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KRST1,
        S_KRST2,
        S_START,
        S_WAIT,
        S_RESP,
        S_TERR1,
        S_TERR2
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_rr;
    logic [IDX_W-1:0]      r_gnt;
    logic [127:0]          r_key_pend;
    logic                  r_key_pend_vld;
    logic [127:0]          r_key_act;
    logic                  r_key_valid;
    logic                  r_core_rst_n;
    logic                  r_core_start;
    logic                  r_core_dec;
    logic [127:0]          r_core_text;
    logic [NUM_REQ-1:0]    r_req_ready;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [127:0]          r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_err;
    logic [WD_W-1:0]       r_wdog;

    // ------------------------------------------------------------------
    // Round-robin pick: candidate k is requester (rr + k) mod NUM_REQ.
    // The lowest k with a valid request wins.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      w_rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0]    w_rot_vld;
    logic [NUM_REQ-1:0]    w_pick_oh;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_any;
    logic [127:0]          w_pick_text;
    logic [IDX_W-1:0]      w_rr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, r_rr} + (IDX_W+1)'(gi);
            assign w_rot_idx[gi] = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                                   IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) :
                                   IDX_W'(w_sum);
            assign w_rot_vld[gi] = i_ReqValid[w_rot_idx[gi]];
            assign w_pick_oh[gi] = (w_pick == IDX_W'(gi));
            assign w_gnt_oh[gi]  = (r_gnt == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_pick = '0;
        // Descending scan so the lowest rotation offset is assigned last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot_vld[k]) begin
                w_pick = w_rot_idx[k];
            end
        end
    end

    assign w_any       = |w_rot_vld;
    assign w_pick_text = i_ReqText[{w_pick, 7'b0} +: 128];
    assign w_rr_next   = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + IDX_W'(1);

    // ------------------------------------------------------------------
    // Scheduler FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state        <= S_IDLE;
            r_rr           <= '0;
            r_gnt          <= '0;
            r_key_pend     <= '0;
            r_key_pend_vld <= 1'b0;
            r_key_act      <= '0;
            r_key_valid    <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_core_start   <= 1'b0;
            r_core_dec     <= 1'b0;
            r_core_text    <= '0;
            r_req_ready    <= '0;
            r_rsp_valid    <= '0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_err          <= 1'b0;
            r_wdog         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Releases the core reset after the system reset.
                    r_core_rst_n <= 1'b1;
                    if (r_key_pend_vld) begin
                        r_core_rst_n <= 1'b0;
                        r_state      <= S_KRST1;
                    end else if (r_key_valid && w_any) begin
                        r_gnt        <= w_pick;
                        r_req_ready  <= w_pick_oh;
                        r_core_text  <= w_pick_text;
                        r_core_dec   <= i_ReqDec[w_pick];
                        r_core_start <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_KRST1: begin
                    r_key_act      <= r_key_pend;
                    r_key_pend_vld <= 1'b0;
                    r_key_valid    <= 1'b1;
                    r_state        <= S_KRST2;
                end
                S_KRST2: begin
                    r_core_rst_n <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_START: begin
                    r_core_start <= 1'b0;
                    r_req_ready  <= '0;
                    r_wdog       <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // Done has priority over a timeout in the same cycle.
                    if (i_CoreDone) begin
                        r_rsp_data  <= i_CoreData;
                        r_rsp_valid <= w_gnt_oh;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (r_wdog == WD_LAST) begin
                        r_rsp_data  <= '0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= w_gnt_oh;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_rsp_err   <= 1'b0;
                    r_rr        <= w_rr_next;
                    if (r_err) begin
                        r_core_rst_n <= 1'b0;
                        r_state      <= S_TERR1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_TERR1: begin
                    r_err   <= 1'b0;
                    r_state <= S_TERR2;
                end
                S_TERR2: begin
                    r_core_rst_n <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A load in any state lands here last, so it wins over the
            // pending-flag clear done in KRST1 on the same edge.
            if (i_KeyLoad) begin
                r_key_pend     <= i_Key;
                r_key_pend_vld <= 1'b1;
            end
        end
    end

    assign o_ReqReady  = r_req_ready;
    assign o_RspValid  = r_rsp_valid;
    assign o_RspData   = r_rsp_data;
    assign o_RspErr    = r_rsp_err;
    assign o_Busy      = (r_state != S_IDLE);
    assign o_KeyValid  = r_key_valid;
    assign o_CoreRst_n = r_core_rst_n;
    assign o_CoreStart = r_core_start;
    assign o_CoreDec   = r_core_dec;
    assign o_CoreText  = r_core_text;
    assign o_CoreKey   = r_key_act;

endmodule

// File: tb/tb_aes_req_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_req_sched
// Directed bench for aes_req_sched. A behavioural core stand-in latches its
// key only on the first start after its reset and answers with FIPS-197
// vectors (or a keyed scramble for other blocks). Expected responses are
// queued when a grant is seen and compared when a response appears.
// -----------------------------------------------------------------------------
module tb_aes_req_sched;

    localparam int N = 4;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KX  = 128'hdeadbeefcafef00d0123456789abcdef;

    logic               i_Clk = 1'b0;
    logic               i_Rst;
    logic               i_KeyLoad;
    logic [127:0]       i_Key;
    logic [N-1:0]       i_ReqValid;
    logic [N-1:0]       i_ReqDec;
    logic [128*N-1:0]   i_ReqText;
    logic [N-1:0]       o_ReqReady;
    logic [N-1:0]       o_RspValid;
    logic [127:0]       o_RspData;
    logic               o_RspErr;
    logic               o_Busy;
    logic               o_KeyValid;
    logic               o_CoreRst_n;
    logic               o_CoreStart;
    logic               o_CoreDec;
    logic [127:0]       o_CoreText;
    logic [127:0]       o_CoreKey;
    logic [127:0]       i_CoreData;
    logic               i_CoreDone;

    aes_req_sched #(.NUM_REQ(N), .IDX_W(2), .TIMEOUT(63)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_KeyLoad(i_KeyLoad), .i_Key(i_Key),
        .i_ReqValid(i_ReqValid), .i_ReqDec(i_ReqDec), .i_ReqText(i_ReqText),
        .o_ReqReady(o_ReqReady), .o_RspValid(o_RspValid), .o_RspData(o_RspData),
        .o_RspErr(o_RspErr), .o_Busy(o_Busy), .o_KeyValid(o_KeyValid),
        .o_CoreRst_n(o_CoreRst_n), .o_CoreStart(o_CoreStart), .o_CoreDec(o_CoreDec),
        .o_CoreText(o_CoreText), .o_CoreKey(o_CoreKey), .i_CoreData(i_CoreData),
        .i_CoreDone(i_CoreDone)
    );

    always #5 i_Clk = ~i_Clk;

    // Result the core produces for (key, text, mode).
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t, input logic d);
        if (k == K1 && !d && t == PT1) return CT1;
        if (k == K1 &&  d && t == CT1) return PT1;
        if (k == K2 && !d && t == PT2) return CT2;
        if (k == K2 &&  d && t == CT2) return PT2;
        if (d) return t ^ k ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
        return t ^ {k[63:0], k[127:64]};
    endfunction

    // ---------------- core stand-in ----------------
    logic         hang = 1'b0;
    int           core_lat = 10;
    logic [127:0] m_key;
    logic         m_keyv;
    logic         m_run;
    int           m_cnt;

    always @(posedge i_Clk) begin
        i_CoreDone <= 1'b0;
        if (!o_CoreRst_n) begin
            m_keyv <= 1'b0;
            m_run  <= 1'b0;
            m_cnt  <= 0;
        end else if (o_CoreStart) begin
            if (!m_keyv) begin
                m_key  <= o_CoreKey;
                m_keyv <= 1'b1;
            end
            m_run <= 1'b1;
            m_cnt <= 1;
        end else if (m_run && !hang) begin
            if (m_cnt == core_lat) begin
                i_CoreDone <= 1'b1;
                i_CoreData <= core_fn(m_key, o_CoreText, o_CoreDec);
                m_run      <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard / monitor state ----------------
    typedef struct {
        int           idx;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           gl[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           lowrun = 0;
    int           last_low = 0;
    int           rst_rise_cyc = 0;
    int           start_cyc = 0;
    int           rsp_cyc = 0;
    int           grant_cyc = 0;
    int           rsp_cnt = 0;
    logic [N-1:0] prev_ready = '0;
    logic         keep_valid = 1'b0;
    logic         exp_err = 1'b0;
    logic [127:0] exp_key = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t         e;
        logic [127:0] oh;
        int           g;
        @(posedge i_Clk);
        #1;
        cyc++;
        if (o_CoreStart) start_cyc = cyc;
        if (!o_CoreRst_n) begin
            lowrun++;
        end else if (lowrun != 0) begin
            last_low     = lowrun;
            lowrun       = 0;
            rst_rise_cyc = cyc;
        end
        if (o_ReqReady != '0) begin
            chk("ready_single_cycle", 128'(prev_ready & o_ReqReady), '0);
            chk("ready_onehot", 128'($countones(o_ReqReady)), 128'd1);
            g = 0;
            for (int r = 0; r < N; r++) if (o_ReqReady[r]) g = r;
            gl.push_back(g);
            grant_cyc = cyc;
            e.idx  = g;
            e.err  = exp_err;
            e.data = exp_err ? '0 : core_fn(exp_key, i_ReqText[g*128 +: 128], i_ReqDec[g]);
            sb.push_back(e);
            if (!keep_valid) i_ReqValid[g] = 1'b0;
        end
        prev_ready = o_ReqReady;
        if (o_RspValid != '0) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'(o_RspValid), '0);
            end else begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                chk("rsp_route", 128'(o_RspValid), oh);
                chk("rsp_data", o_RspData, e.data);
                chk("rsp_err", 128'(o_RspErr), 128'(e.err));
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget && rsp_cnt < target; i++) step();
        chk("rsp_wait", 128'(rsp_cnt >= target), 128'd1);
    endtask

    task automatic wait_grant(input int target, input int budget);
        for (int i = 0; i < budget && gl.size() < target; i++) step();
        chk("grant_wait", 128'(gl.size() >= target), 128'd1);
    endtask

    task automatic set_req(input int r, input logic [127:0] t, input logic d);
        i_ReqText[r*128 +: 128] = t;
        i_ReqDec[r]   = d;
        i_ReqValid[r] = 1'b1;
    endtask

    task automatic key_load(input logic [127:0] k);
        i_Key     = k;
        i_KeyLoad = 1'b1;
        step();
        i_KeyLoad = 1'b0;
    endtask

    int rsp1_cyc;
    int rsp_before;
    int gbase;

    initial begin
        i_Rst      = 1'b0;
        i_KeyLoad  = 1'b0;
        i_Key      = '0;
        i_ReqValid = '0;
        i_ReqDec   = '0;
        i_ReqText  = '0;

        // Reset state
        steps(3);
        chk("rst_core_rst_n", 128'(o_CoreRst_n), 128'd0);
        chk("rst_busy", 128'(o_Busy), 128'd0);
        chk("rst_keyvalid", 128'(o_KeyValid), 128'd0);
        chk("rst_corekey", o_CoreKey, '0);
        chk("rst_start", 128'(o_CoreStart), 128'd0);
        i_Rst = 1'b1;
        lowrun = 0;
        step();
        chk("post_rst_core_rst_n", 128'(o_CoreRst_n), 128'd1);

        // No key: request is never granted
        set_req(0, PT1, 1'b0);
        steps(20);
        chk("nokey_no_grant", 128'(gl.size()), 128'd0);
        chk("nokey_idle", 128'(o_Busy), 128'd0);

        // Test 1: install K1, encrypt on requester 0
        exp_key = K1;
        key_load(K1);
        wait_rsp(1, 100);
        chk("krst_len", 128'(last_low), 128'd2);
        chk("keyvalid", 128'(o_KeyValid), 128'd1);
        chk("corekey_k1", o_CoreKey, K1);

        // Test 2: decrypt on requester 2
        set_req(2, CT1, 1'b1);
        wait_rsp(2, 100);

        // Test 3: all requesters held valid; rr pointer sits at 3
        for (int r = 0; r < N; r++)
            set_req(r, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        keep_valid = 1'b1;
        gbase = gl.size();
        wait_rsp(7, 200);
        i_ReqValid = '0;
        keep_valid = 1'b0;
        chk("rr_g0", 128'(gl[gbase+0]), 128'd3);
        chk("rr_g1", 128'(gl[gbase+1]), 128'd0);
        chk("rr_g2", 128'(gl[gbase+2]), 128'd1);
        chk("rr_g3", 128'(gl[gbase+3]), 128'd2);
        chk("rr_g4", 128'(gl[gbase+4]), 128'd3);
        steps(3);
        chk("rr_no_extra_grant", 128'(gl.size()), 128'(gbase + 5));

        // Test 4: key load (twice, last wins) while a K1 job is in WAIT
        set_req(1, PT1, 1'b0);
        wait_grant(gbase + 6, 50);
        steps(2);
        chk("wait_busy", 128'(o_Busy), 128'd1);
        key_load(KX);
        key_load(K2);
        exp_key = K2;
        chk("key_held_in_wait", o_CoreKey, K1);
        set_req(2, PT2, 1'b0);
        wait_rsp(8, 100);
        rsp1_cyc = rsp_cyc;
        wait_rsp(9, 100);
        chk("krst_after_rsp", 128'(rst_rise_cyc > rsp1_cyc), 128'd1);
        chk("krst_before_grant", 128'(rst_rise_cyc < grant_cyc), 128'd1);
        chk("corekey_k2", o_CoreKey, K2);

        // Test 5a: hung core -> timeout error 64 cycles after start
        hang = 1'b1;
        exp_err = 1'b1;
        set_req(0, PT2, 1'b0);
        wait_rsp(10, 150);
        chk("timeout_latency", 128'(rsp_cyc - start_cyc), 128'd64);
        steps(4);
        chk("terr_len", 128'(last_low), 128'd2);
        chk("terr_key_kept", o_CoreKey, K2);
        hang = 1'b0;
        exp_err = 1'b0;
        set_req(1, CT2, 1'b1);
        wait_rsp(11, 100);

        // Test 5b: done exactly on the timeout cycle -> no error
        core_lat = 62;
        set_req(2, PT2, 1'b0);
        wait_rsp(12, 150);
        chk("done_at_timeout_latency", 128'(rsp_cyc - start_cyc), 128'd64);

        // Test 5c: done one cycle late -> timeout wins, late done ignored
        core_lat = 63;
        exp_err = 1'b1;
        set_req(3, PT1, 1'b0);
        wait_rsp(13, 150);
        chk("late_done_latency", 128'(rsp_cyc - start_cyc), 128'd64);
        steps(5);
        chk("late_done_idle", 128'(o_Busy), 128'd0);
        core_lat = 10;
        exp_err = 1'b0;

        // Test 6: reset in the middle of WAIT aborts without a response
        set_req(0, PT2, 1'b0);
        wait_grant(gl.size() + 1, 50);
        steps(3);
        i_Rst = 1'b0;
        #1;
        chk("abort_busy", 128'(o_Busy), 128'd0);
        chk("abort_keyvalid", 128'(o_KeyValid), 128'd0);
        chk("abort_core_rst_n", 128'(o_CoreRst_n), 128'd0);
        chk("abort_corekey", o_CoreKey, '0);
        chk("abort_coretext", o_CoreText, '0);
        chk("abort_rspvalid", 128'(o_RspValid), '0);
        sb.delete();
        i_ReqValid = '0;
        rsp_before = rsp_cnt;
        steps(2);
        i_Rst = 1'b1;
        steps(30);
        chk("abort_no_rsp", 128'(rsp_cnt), 128'(rsp_before));
        chk("abort_core_rst_released", 128'(o_CoreRst_n), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
